// File: rtl/gtx_rx_reset_seq.sv
// Receive-side reset sequencer for one GTX lane: pulses RX reset, waits for
// reset-done, pulses the elastic buffer reset, qualifies alignment, then
// raises link_ready. Timeouts retry automatically and are counted.
module gtx_rx_reset_seq #(
    parameter int RST_CYCLES   = 16,
    parameter int DONE_TIMEOUT = 4096,
    parameter int BUF_CYCLES   = 8,
    parameter int SYNC_STABLE  = 64,
    parameter int SYNC_TIMEOUT = 65536
) (
    input  logic       clk,
    input  logic       rst_in,
    input  logic       req_rst,
    input  logic       rxresetdone,
    input  logic       rxbyteisaligned,
    input  logic       rxlossofsync,
    output logic       rx_reset,
    output logic       rx_buf_reset,
    output logic       link_ready,
    output logic [7:0] retry_cnt,
    output logic [2:0] seq_state
);

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_DONE = 3'd1,
        ST_BUF_RST   = 3'd2,
        ST_WAIT_SYNC = 3'd3,
        ST_READY     = 3'd4
    } state_t;

    localparam logic [16:0] RST_LOAD  = 17'(RST_CYCLES - 1);
    localparam logic [16:0] DONE_LOAD = 17'(DONE_TIMEOUT - 1);
    localparam logic [16:0] BUF_LOAD  = 17'(BUF_CYCLES - 1);
    localparam logic [16:0] SYNC_LOAD = 17'(SYNC_TIMEOUT - 1);
    // stability counter must be able to hold SYNC_STABLE itself
    localparam int SW = ($clog2(SYNC_STABLE + 1) > 7) ? $clog2(SYNC_STABLE + 1) : 7;
    localparam logic [SW-1:0] STAB_TGT = SW'(SYNC_STABLE);

    logic          req_m, req_s;
    state_t        state, state_nxt;
    logic [16:0]   cnt, cnt_nxt;
    logic [SW-1:0] stab, stab_nxt;
    logic          retry_inc;

    // two-flop synchroniser for the asynchronous reset request level
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            req_m <= 1'b0;
            req_s <= 1'b0;
        end else begin
            req_m <= req_rst;
            req_s <= req_m;
        end
    end

    // state, shared down-counter and stability counter
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            state <= ST_RESET;
            cnt   <= RST_LOAD;
            stab  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            stab  <= stab_nxt;
        end
    end

    // next-state logic; a synchronised request overrides every other transition
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stab_nxt  = '0;
        retry_inc = 1'b0;
        case (state)
            ST_RESET: begin
                if (cnt == '0) begin
                    state_nxt = ST_WAIT_DONE;
                    cnt_nxt   = DONE_LOAD;
                end else begin
                    cnt_nxt = cnt - 17'd1;
                end
            end
            ST_WAIT_DONE: begin
                if (rxresetdone) begin
                    state_nxt = ST_BUF_RST;
                    cnt_nxt   = BUF_LOAD;
                end else if (cnt == '0) begin
                    state_nxt = ST_RESET;
                    cnt_nxt   = RST_LOAD;
                    retry_inc = 1'b1;
                end else begin
                    cnt_nxt = cnt - 17'd1;
                end
            end
            ST_BUF_RST: begin
                if (cnt == '0) begin
                    state_nxt = ST_WAIT_SYNC;
                    cnt_nxt   = SYNC_LOAD;
                end else begin
                    cnt_nxt = cnt - 17'd1;
                end
            end
            ST_WAIT_SYNC: begin
                if (stab == STAB_TGT) begin
                    state_nxt = ST_READY;
                end else if (cnt == '0) begin
                    state_nxt = ST_RESET;
                    cnt_nxt   = RST_LOAD;
                    retry_inc = 1'b1;
                end else begin
                    cnt_nxt  = cnt - 17'd1;
                    stab_nxt = (rxbyteisaligned && !rxlossofsync) ? stab + 1'b1 : '0;
                end
            end
            ST_READY: begin
                // alignment loss here is handled by upstream detectors
                state_nxt = ST_READY;
            end
            default: begin
                state_nxt = ST_RESET;
                cnt_nxt   = RST_LOAD;
            end
        endcase
        if (req_s) begin
            state_nxt = ST_RESET;
            cnt_nxt   = RST_LOAD;
            stab_nxt  = '0;
            retry_inc = 1'b0;
        end
    end

    // registered outputs, decoded from the state being entered
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            rx_reset     <= 1'b1;
            rx_buf_reset <= 1'b0;
            link_ready   <= 1'b0;
            retry_cnt    <= 8'd0;
        end else begin
            rx_reset     <= (state_nxt == ST_RESET);
            rx_buf_reset <= (state_nxt == ST_BUF_RST);
            link_ready   <= (state_nxt == ST_READY);
            if (retry_inc && retry_cnt != 8'hFF)
                retry_cnt <= retry_cnt + 8'd1;
        end
    end

    assign seq_state = state;

endmodule

// File: tb/tb_gtx_rx_reset_seq.sv
// Scoreboard bench for gtx_rx_reset_seq: the stimulus computes the cycle of
// every expected state change from phase durations and queues it; a monitor
// pops and compares whenever the DUT outputs change.
module tb_gtx_rx_reset_seq;

    localparam int RST = 16, DT = 128, BUF = 8, SS = 64, STO = 512;
    localparam int S_RESET = 0, S_WD = 1, S_BUF = 2, S_WS = 3, S_RDY = 4;

    typedef struct packed {
        logic [2:0] st;
        logic       rr;
        logic       br;
        logic       lr;
        logic [7:0] rc;
    } obs_t;

    typedef struct {
        int   cyc;
        obs_t o;
    } ev_t;

    logic       clk = 1'b0, rst_in = 1'b1, req_rst = 1'b0;
    logic       done = 1'b0, aligned = 1'b0, los = 1'b0;
    logic       rx_reset, rx_buf_reset, link_ready;
    logic [7:0] retry_cnt;
    logic [2:0] seq_state;

    int   cyc = 0;
    int   checks = 0, failures = 0;
    int   exp_rc = 0;
    int   overlap = 0;
    ev_t  ev_q[$];
    obs_t mon_prev = {3'd0, 1'b1, 1'b0, 1'b0, 8'd0};
    obs_t mon_cur;
    ev_t  mon_e;

    gtx_rx_reset_seq #(
        .RST_CYCLES(RST), .DONE_TIMEOUT(DT), .BUF_CYCLES(BUF),
        .SYNC_STABLE(SS), .SYNC_TIMEOUT(STO)
    ) dut (
        .clk(clk), .rst_in(rst_in), .req_rst(req_rst),
        .rxresetdone(done), .rxbyteisaligned(aligned), .rxlossofsync(los),
        .rx_reset(rx_reset), .rx_buf_reset(rx_buf_reset), .link_ready(link_ready),
        .retry_cnt(retry_cnt), .seq_state(seq_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // expected outputs for a given state, from the decode rules
    function automatic obs_t mk(input int st);
        obs_t o;
        o.st = 3'(st);
        o.rr = (st == S_RESET);
        o.br = (st == S_BUF);
        o.lr = (st == S_RDY);
        o.rc = 8'(exp_rc);
        return o;
    endfunction

    task automatic push(input int c, input int st);
        ev_t e;
        e.cyc = c;
        e.o   = mk(st);
        ev_q.push_back(e);
    endtask

    task automatic retry_step();
        exp_rc = (exp_rc < 255) ? exp_rc + 1 : 255;
    endtask

    // advance to 1 time unit after the edge that makes cyc == c
    task automatic wait_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // monitor: every change of the output tuple must match the next expected event
    always @(negedge clk) begin
        mon_cur = {seq_state, rx_reset, rx_buf_reset, link_ready, retry_cnt};
        if (rx_reset && rx_buf_reset) overlap++;
        if (mon_cur != mon_prev) begin
            if (ev_q.size() == 0) begin
                check("unexpected_change", 32'(mon_cur), 32'(mon_prev));
            end else begin
                mon_e = ev_q.pop_front();
                check("event_cycle", 32'(cyc), 32'(mon_e.cyc));
                check("event_outputs", 32'(mon_cur), 32'(mon_e.o));
            end
            mon_prev = mon_cur;
        end
    end

    initial begin
        int t, c, p, w, r, e, k, use_los;

        #2 rst_in = 1'b0;
        wait_to(3);
        check("reset_rx_reset", 32'(rx_reset), 1);
        check("reset_rx_buf_reset", 32'(rx_buf_reset), 0);
        check("reset_link_ready", 32'(link_ready), 0);
        check("reset_retry_cnt", 32'(retry_cnt), 0);
        check("reset_seq_state", 32'(seq_state), 0);

        // nominal bring-up: done arrives 100 cycles after rx_reset falls
        t = cyc;
        rst_in = 1'b1;
        push(t + RST, S_WD);
        wait_to(t + RST + 99);
        done = 1'b1;
        aligned = 1'b1;
        push(t + RST + 100, S_BUF);
        w = t + RST + 100 + BUF;
        push(w, S_WS);
        push(w + 1 + SS, S_RDY);
        wait_to(w + SS + 10);

        // request pulse of 10 cycles while READY
        c = cyc;
        req_rst = 1'b1;
        push(c + 3, S_RESET);
        wait_to(c + 10);
        req_rst = 1'b0;
        p = c + 10;
        push(p + 2 + RST, S_WD);
        push(p + 3 + RST, S_BUF);
        w = p + 3 + RST + BUF;
        push(w, S_WS);
        push(w + 1 + SS, S_RDY);
        wait_to(w + SS + 10);

        // alignment glitches: first at stable count 63, then random count/kind
        for (int i = 0; i < 4; i++) begin
            k = (i == 0) ? 63 : int'($urandom_range(0, 62));
            use_los = (i == 0) ? 0 : int'($urandom_range(0, 1));
            aligned = 1'b0;
            c = cyc;
            req_rst = 1'b1;
            push(c + 3, S_RESET);
            wait_to(c + 1);
            req_rst = 1'b0;
            p = c + 1;
            push(p + 2 + RST, S_WD);
            push(p + 3 + RST, S_BUF);
            w = p + 3 + RST + BUF;
            push(w, S_WS);
            wait_to(w);
            aligned = 1'b1;
            wait_to(w + k);
            if (use_los != 0) los = 1'b1;
            else aligned = 1'b0;
            wait_to(w + k + 1);
            los = 1'b0;
            aligned = 1'b1;
            push(w + k + 2 + SS, S_RDY);
            wait_to(w + k + 2 + SS + 5);
        end

        // sync timeout with loss-of-sync held, then request on a done-timeout edge
        c = cyc;
        los = 1'b1;
        req_rst = 1'b1;
        push(c + 3, S_RESET);
        wait_to(c + 1);
        req_rst = 1'b0;
        p = c + 1;
        push(p + 2 + RST, S_WD);
        push(p + 3 + RST, S_BUF);
        w = p + 3 + RST + BUF;
        push(w, S_WS);
        wait_to(w + 10);
        done = 1'b0;
        retry_step();
        r = w + STO;
        push(r, S_RESET);
        push(r + RST, S_WD);
        e = r + RST + DT;
        wait_to(r + 5);
        los = 1'b0;
        wait_to(e - 3);
        req_rst = 1'b1;
        push(e, S_RESET);
        wait_to(e - 2);
        req_rst = 1'b0;
        wait_to(e + 1);
        done = 1'b1;
        push(e + RST, S_WD);
        push(e + RST + 1, S_BUF);
        w = e + RST + 1 + BUF;
        push(w, S_WS);
        push(w + 1 + SS, S_RDY);
        wait_to(w + SS + 10);

        // 300 forced done timeouts: retry_cnt steps then saturates at 255
        done = 1'b0;
        c = cyc;
        req_rst = 1'b1;
        push(c + 3, S_RESET);
        r = c + 3;
        for (int n = 0; n < 300; n++) begin
            push(r + RST, S_WD);
            retry_step();
            push(r + RST + DT, S_RESET);
            r = r + RST + DT;
        end
        wait_to(c + 1);
        req_rst = 1'b0;
        wait_to(r + 5);
        check("retry_saturated", 32'(retry_cnt), 255);

        // asynchronous reset asserted mid-BUF_RST
        done = 1'b1;
        push(r + RST, S_WD);
        push(r + RST + 1, S_BUF);
        wait_to(r + RST + 4);
        #2;
        exp_rc = 0;
        push(r + RST + 4, S_RESET);
        rst_in = 1'b0;
        #1;
        check("async_rx_reset", 32'(rx_reset), 1);
        check("async_rx_buf_reset", 32'(rx_buf_reset), 0);
        check("async_link_ready", 32'(link_ready), 0);
        check("async_retry_cnt", 32'(retry_cnt), 0);
        check("async_seq_state", 32'(seq_state), 0);

        // minimum-latency bring-up with done and alignment already high
        wait_to(r + RST + 7);
        t = cyc;
        rst_in = 1'b1;
        push(t + RST, S_WD);
        push(t + RST + 1, S_BUF);
        push(t + RST + 1 + BUF, S_WS);
        push(t + RST + 1 + BUF + SS + 1, S_RDY);
        wait_to(t + RST + BUF + SS + 20);

        check("events_pending", 32'(ev_q.size()), 0);
        check("reset_overlap", 32'(overlap), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gtx_rx_reset_seq.md
# gtx_rx_reset_seq

Receive-side reset sequencer for one GTX lane, downstream of the lane reset generator. Synchronises the generator's `gtx_rst_out` level into the GTX user clock domain and pulses the transceiver RX reset. It waits for `RXRESETDONE`, then resets the elastic buffer and qualifies alignment. Only after alignment qualifies does it assert `link_ready` to the lane's user logic. Timeouts trigger automatic retries, and retries are counted for debug.

## Interface
Parameters:
- `RST_CYCLES`, 16: width of the `rx_reset` pulse in `clk` cycles (≥1).
- `DONE_TIMEOUT`, 4096: maximum wait for `rxresetdone`, in `clk` cycles.
- `BUF_CYCLES`, 8: width of the `rx_buf_reset` pulse (≥1).
- `SYNC_STABLE`, 64: consecutive aligned cycles required before ready.
- `SYNC_TIMEOUT`, 65536: maximum wait for stable alignment, in cycles.

Ports:
- `clk`  in  1  GTX RX user clock.
- `rst_in`  in  1  asynchronous, active-low reset.
- `req_rst`  in  1  reset request level from the lane reset generator; asynchronous to `clk`.
- `rxresetdone`  in  1  GTX RX reset-done flag.
- `rxbyteisaligned`  in  1  GTX comma alignment flag.
- `rxlossofsync`  in  1  GTX loss-of-sync status bit.
- `rx_reset`  out  1  GTX RX reset, active-high.
- `rx_buf_reset`  out  1  GTX RX elastic buffer reset, active-high.
- `link_ready`  out  1  lane qualified; user logic may consume data.
- `retry_cnt`  out  8  saturating count of timeout-induced retries.
- `seq_state`  out  3  current state encoding, for debug.

## Operation
- `req_rst` passes through a 2-flop synchroniser; call the result `req_s`. All other inputs are treated as synchronous to `clk`.
- State encodings: `RESET`=0, `WAIT_DONE`=1, `BUF_RST`=2, `WAIT_SYNC`=3, `READY`=4. Values 5–7 are illegal and go to `RESET` on the next cycle.
- One down-counter, 17 bits wide, is shared by all states. It is loaded on every state entry.
- `RESET`:
  - `rx_reset`=1.
  - The counter loads `RST_CYCLES-1`.
  - When the counter is 0 and `req_s`=0, go to `WAIT_DONE`.
  - While `req_s`=1, the counter holds its load value, so the state stays in `RESET`.
- `WAIT_DONE`:
  - The counter loads `DONE_TIMEOUT-1`.
  - `rxresetdone`=1 → `BUF_RST`.
  - Counter reaches 0 without done → `RESET`, and `retry_cnt` increments.
- `BUF_RST`:
  - `rx_buf_reset`=1 for exactly `BUF_CYCLES` cycles, then go to `WAIT_SYNC`.
- `WAIT_SYNC`:
  - A stability counter (7 bits or wider) increments on each cycle with `rxbyteisaligned`=1 and `rxlossofsync`=0. Any other cycle clears it.
  - Stability count reaches `SYNC_STABLE` → `READY`.
  - Timeout counter reaches 0 first → `RESET`, and `retry_cnt` increments.
- `READY`:
  - `link_ready`=1.
  - The block leaves `READY` only on `req_s`=1.
  - Alignment loss in `READY` is ignored here; the upstream detectors are responsible for it.
- `req_s`=1 in any state other than `RESET` → `RESET` on the next edge. This request has priority over every other transition, including a timeout or completion in the same cycle. In that case `retry_cnt` does not increment.
- `retry_cnt`:
  - Saturates at 255.
  - Cleared only by `rst_in`.
  - Retries caused by `req_s` are not counted.

## Timing
- Reset values while `rst_in`=0:
  - state `RESET`; `rx_reset`=1.
  - `rx_buf_reset`=0, `link_ready`=0, `retry_cnt`=0, `seq_state`=0.
  - Synchroniser flops 0; counter loaded to `RST_CYCLES-1`.
- Release of `rst_in` with `req_rst`=0:
  - `rx_reset` stays high for `RST_CYCLES` edges.
  - It falls on the edge that enters `WAIT_DONE`.
- All outputs are registered and decoded from the current state. There is no combinational path from input to output.
- `req_rst` rising → `link_ready` falls and `rx_reset` rises 3 edges later (2 synchroniser edges + 1 state edge).
- `rxresetdone` seen high at edge N → `rx_buf_reset` is high from edge N+1 for `BUF_CYCLES` cycles.
- `link_ready` rises on the edge after the stability counter hits `SYNC_STABLE`.
- Minimum from reset release to `link_ready`: `RST_CYCLES` + 1 + `BUF_CYCLES` + `SYNC_STABLE` + 1 edges, given `rxresetdone` already high.
- `rx_reset` and `rx_buf_reset` are never high together.

## Test plan
- Nominal bring-up:
  - Stimulus: `rst_in` release; `rxresetdone` rises 100 cycles after `rx_reset` falls; aligned thereafter.
  - Required: `rx_reset` high exactly 16 cycles; `rx_buf_reset` high 8 cycles; `link_ready` rises 64 cycles after aligned; `retry_cnt`=0.
- Done timeout:
  - Stimulus: `rxresetdone` held low.
  - Required: return to `RESET` every 16+4096 cycles; `retry_cnt` steps 1,2,3…; after forcing 300 timeouts it holds at 255.
- Alignment glitch:
  - Stimulus: in `WAIT_SYNC`, `rxbyteisaligned` drops for 1 cycle at stable count 63.
  - Required: count clears; `link_ready` rises only after 64 further clean cycles.
- Sync timeout:
  - Stimulus: `rxlossofsync`=1 throughout `WAIT_SYNC`.
  - Required: `RESET` after 65536 cycles; `retry_cnt` +1.
- Request during operation:
  - Stimulus: `req_rst` pulsed high 10 cycles while in `READY`.
  - Required: `link_ready`=0 and `rx_reset`=1 exactly 3 edges after the rise; `rx_reset` stays high ≥ 16 cycles after `req_s` falls; `retry_cnt` unchanged.
- Simultaneous events and mid-sequence reset:
  - Stimulus 1: `req_s` rises on the same edge as `WAIT_DONE` timeout.
  - Required: go to `RESET` with `retry_cnt` unchanged.
  - Stimulus 2: assert `rst_in` mid-`BUF_RST`.
  - Required: all outputs return to reset values asynchronously.
